// File: rtl/avmm_lvds_bridge_req_arb_if.sv
// Bus bundle for the AVMM-LVDS bridge request arbiter: two command front-ends,
// the ch1 write-data stream, the packet output and the read-tag FIFO head.
interface avmm_lvds_bridge_req_arb_if #(
  parameter int ADDR_W     = 32,
  parameter int BURSTCNT_W = 4
);
  logic                  c0_valid_i;
  logic                  c0_ready_o;
  logic                  c0_write_i;
  logic [ADDR_W-1:0]     c0_addr_i;
  logic [3:0]            c0_be_i;
  logic [31:0]           c0_wdata_i;

  logic                  c1_valid_i;
  logic                  c1_ready_o;
  logic                  c1_write_i;
  logic [ADDR_W-1:0]     c1_addr_i;
  logic [BURSTCNT_W-1:0] c1_burstcount_i;
  logic                  c1_wvalid_i;
  logic                  c1_wready_o;
  logic [31:0]           c1_wdata_i;

  logic [31:0]           pkt_data_o;
  logic                  pkt_valid_o;
  logic                  pkt_ready_i;
  logic                  pkt_sop_o;
  logic                  pkt_eop_o;

  logic                  tag_valid_o;
  logic                  tag_ready_i;
  logic                  tag_ch_o;
  logic [7:0]            tag_len_o;

  modport slave (
    input  c0_valid_i, c0_write_i, c0_addr_i, c0_be_i, c0_wdata_i,
    output c0_ready_o,
    input  c1_valid_i, c1_write_i, c1_addr_i, c1_burstcount_i, c1_wvalid_i, c1_wdata_i,
    output c1_ready_o, c1_wready_o,
    output pkt_data_o, pkt_valid_o, pkt_sop_o, pkt_eop_o,
    input  pkt_ready_i,
    output tag_valid_o, tag_ch_o, tag_len_o,
    input  tag_ready_i
  );

  modport master (
    output c0_valid_i, c0_write_i, c0_addr_i, c0_be_i, c0_wdata_i,
    input  c0_ready_o,
    output c1_valid_i, c1_write_i, c1_addr_i, c1_burstcount_i, c1_wvalid_i, c1_wdata_i,
    input  c1_ready_o, c1_wready_o,
    input  pkt_data_o, pkt_valid_o, pkt_sop_o, pkt_eop_o,
    output pkt_ready_i,
    input  tag_valid_o, tag_ch_o, tag_len_o,
    output tag_ready_i
  );
endinterface

// File: rtl/avmm_lvds_bridge_req_arb.sv
// Request arbiter/packetizer: grants ch0 or ch1, emits header + write data as one
// 32-bit packet stream, and queues a response tag per read. Define
// AVMM_LVDS_BRIDGE_ARB_PRIO_EN for fixed ch0 priority instead of round-robin.
module avmm_lvds_bridge_req_arb #(
  parameter int ADDR_W     = 32,
  parameter int BURSTCNT_W = 4,
  parameter int TAG_DEPTH  = 4
) (
  input logic                       clk_i,
  input logic                       rst_ni,
  avmm_lvds_bridge_req_arb_if.slave bus
);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, HDR0, HDR1, DATA} state_t;
  typedef struct packed {
    logic       ch;
    logic [7:0] len;
  } tag_t;

  state_t            state_q, state_d;
  logic              gnt_ch_q, gnt_write_q;
  logic [3:0]        gnt_be_q;
  logic [7:0]        gnt_len_q;
  logic [ADDR_W-1:0] gnt_addr_q;
  logic [31:0]       gnt_wdata_q;
  logic [7:0]        beat_q;

  tag_t              tag_mem [TAG_DEPTH];
  tag_t              tag_head;
  logic [PTR_W-1:0]  tag_wr_q, tag_rd_q;
  logic [CNT_W-1:0]  tag_cnt_q;
  logic              tag_full, tag_valid, tag_push, tag_push_ok, tag_pop;

  logic              elig0, elig1, sel1, grant;
  logic [7:0]        c1_len;
  logic [31:0]       hdr_word, addr_word, pkt_data;
  logic              pkt_valid, pkt_sop, pkt_eop, pkt_fire;
  logic              c0_ready, c1_ready, c1_wready;

`ifndef AVMM_LVDS_BRIDGE_ARB_PRIO_EN
  logic              rr_last_q;  // channel granted most recently
`endif

  assign tag_full  = (tag_cnt_q == CNT_W'(TAG_DEPTH));
  assign tag_valid = (tag_cnt_q != '0);
  assign tag_pop   = tag_valid && bus.tag_ready_i;
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign tag_push_ok = tag_push && (!tag_full || tag_pop);
  assign tag_head  = tag_mem[tag_rd_q];

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    c1_len = '0;
    c1_len[BURSTCNT_W-1:0] = bus.c1_burstcount_i;
    if (c1_len == 8'd0) c1_len = 8'd1;
    elig0 = bus.c0_valid_i && (bus.c0_write_i || !tag_full);
    elig1 = bus.c1_valid_i && (bus.c1_write_i || !tag_full);
`ifdef AVMM_LVDS_BRIDGE_ARB_PRIO_EN
    sel1 = elig1 && !elig0;
`else
    sel1 = elig1 && (!elig0 || !rr_last_q);
`endif
  end

  always_comb begin
    hdr_word  = {gnt_write_q, gnt_ch_q, 18'd0, gnt_be_q, gnt_len_q};
    addr_word = '0;
    addr_word[ADDR_W-1:0] = gnt_addr_q;
  end

  always_comb begin
    state_d   = state_q;
    pkt_valid = 1'b0;
    pkt_data  = '0;
    pkt_sop   = 1'b0;
    pkt_eop   = 1'b0;
    c0_ready  = 1'b0;
    c1_ready  = 1'b0;
    c1_wready = 1'b0;
    grant     = 1'b0;
    tag_push  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (elig0 || elig1) begin
          grant   = 1'b1;
          state_d = HDR0;
        end
      end
      HDR0: begin
        pkt_valid = 1'b1;
        pkt_sop   = 1'b1;
        pkt_data  = hdr_word;
        if (bus.pkt_ready_i) state_d = HDR1;
      end
      HDR1: begin
        pkt_valid = 1'b1;
        pkt_eop   = !gnt_write_q;
        pkt_data  = addr_word;
        if (bus.pkt_ready_i) begin
          c0_ready = !gnt_ch_q;
          c1_ready = gnt_ch_q;
          tag_push = !gnt_write_q;
          state_d  = gnt_write_q ? DATA : IDLE;
        end
      end
      DATA: begin
        pkt_eop = (beat_q == 8'd1);
        if (gnt_ch_q) begin
          pkt_valid = bus.c1_wvalid_i;
          pkt_data  = bus.c1_wdata_i;
          c1_wready = bus.pkt_ready_i;
        end else begin
          pkt_valid = 1'b1;
          pkt_data  = gnt_wdata_q;
        end
        if (pkt_valid && bus.pkt_ready_i && beat_q == 8'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pkt_fire = pkt_valid && bus.pkt_ready_i;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      gnt_ch_q    <= 1'b0;
      gnt_write_q <= 1'b0;
      gnt_be_q    <= '0;
      gnt_len_q   <= '0;
      gnt_addr_q  <= '0;
      gnt_wdata_q <= '0;
      beat_q      <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        gnt_ch_q    <= sel1;
        gnt_write_q <= sel1 ? bus.c1_write_i : bus.c0_write_i;
        gnt_be_q    <= sel1 ? 4'hF : bus.c0_be_i;
        gnt_len_q   <= sel1 ? c1_len : 8'd1;
        gnt_addr_q  <= sel1 ? bus.c1_addr_i : bus.c0_addr_i;
        gnt_wdata_q <= bus.c0_wdata_i;
      end
      if (state_q == HDR1 && pkt_fire && gnt_write_q) beat_q <= gnt_len_q;
      else if (state_q == DATA && pkt_fire)           beat_q <= beat_q - 8'd1;
    end
  end

`ifndef AVMM_LVDS_BRIDGE_ARB_PRIO_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    rr_last_q <= 1'b1;
    else if (grant) rr_last_q <= sel1;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      tag_cnt_q <= '0;
    end else begin
      if (tag_push_ok) tag_wr_q <= tag_wr_q + 1'b1;
      if (tag_pop)     tag_rd_q <= tag_rd_q + 1'b1;
      unique case ({tag_push_ok, tag_pop})
        2'b10:   tag_cnt_q <= tag_cnt_q + 1'b1;
        2'b01:   tag_cnt_q <= tag_cnt_q - 1'b1;
        default: tag_cnt_q <= tag_cnt_q;
      endcase
    end
  end

  // NOTE: storage is not reset; the occupancy counter alone defines valid entries.
  always_ff @(posedge clk_i) begin
    if (tag_push_ok) tag_mem[tag_wr_q] <= '{ch: gnt_ch_q, len: gnt_len_q};
  end

  assign bus.pkt_valid_o = pkt_valid;
  assign bus.pkt_data_o  = pkt_data;
  assign bus.pkt_sop_o   = pkt_sop;
  assign bus.pkt_eop_o   = pkt_eop;
  assign bus.c0_ready_o  = c0_ready;
  assign bus.c1_ready_o  = c1_ready;
  assign bus.c1_wready_o = c1_wready;
  assign bus.tag_valid_o = tag_valid;
  assign bus.tag_ch_o    = tag_valid ? tag_head.ch  : 1'b0;
  assign bus.tag_len_o   = tag_valid ? tag_head.len : 8'd0;
endmodule
